// File: rtl/alu_res_pkg.sv
// Shared types and constants for the ALU result serializer.
// ALU_RES_HDR_EN adds a header byte state and makes each frame three bytes long.
package alu_res_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam logic [7:0]  DEF_HDR_BYTE   = 8'hA5;

`ifdef ALU_RES_HDR_EN
  localparam int unsigned FRAME_BYTES = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_LO  = 2'd1,
    SEND_HI  = 2'd2,
    SEND_HDR = 2'd3
  } ser_state_t;
`else
  localparam int unsigned FRAME_BYTES = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } ser_state_t;
`endif

endpackage

// File: rtl/alu_result_serializer_if.sv
// ALU-result input / TX-byte output bundle of the serializer.
// The slave modport is the serializer; the master modport is the ALU, controller and TX FIFO side.
interface alu_result_serializer_if
  import alu_res_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned RESULT_WIDTH = 2 * DATA_WIDTH
);

  logic [RESULT_WIDTH-1:0] ALU_OUT;
  logic                    OUT_VALID;
  logic [DATA_WIDTH-1:0]   TX_DATA;
  logic                    TX_VALID;
  logic                    TX_READY;
  logic                    BUSY;
  logic                    OVERRUN;
  logic                    CLR_OVERRUN;

  modport slave (
    input  ALU_OUT, OUT_VALID, TX_READY, CLR_OVERRUN,
    output TX_DATA, TX_VALID, BUSY, OVERRUN
  );

  modport master (
    output ALU_OUT, OUT_VALID, TX_READY, CLR_OVERRUN,
    input  TX_DATA, TX_VALID, BUSY, OVERRUN
  );

endinterface

// File: rtl/alu_res_hold.sv
// One-entry holding buffer for an ALU result that arrives while the previous one drains.
// A write in the same cycle as a pop refills the entry, so the buffer stays full.
module alu_res_hold
  import alu_res_pkg::*;
#(
  parameter int unsigned WIDTH = 2 * DEF_DATA_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             full_q, full_d;

  // A write to a full, non-popping entry is ignored; the parent flags it as an overrun.
  always_comb begin : hold_next
    data_d = data_q;
    full_d = full_q;
    if (wr_i && (!full_q || pop_i)) begin
      data_d = din_i;
      full_d = 1'b1;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin : hold_reg
    if (!RST) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign dout_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/alu_result_serializer.sv
// Splits each 16-bit ALU result into bytes (LSB first) for the UART TX FIFO writer.
// Define ALU_RES_HDR_EN to prefix every frame with HDR_BYTE.
module alu_result_serializer
  import alu_res_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned           RESULT_WIDTH = 2 * DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] HDR_BYTE     = DATA_WIDTH'(DEF_HDR_BYTE)
) (
  input  logic                     CLK,
  input  logic                     RST,
  alu_result_serializer_if.slave   bus
);

  // Reject configurations whose result is not exactly two bytes.
  if (RESULT_WIDTH != 2 * DATA_WIDTH || FRAME_BYTES < 2 ||
      $bits(HDR_BYTE) != DATA_WIDTH) begin : g_bad_cfg
    $error("alu_result_serializer: RESULT_WIDTH must equal 2*DATA_WIDTH");
  end

`ifdef ALU_RES_HDR_EN
  localparam ser_state_t FIRST_ST = SEND_HDR;
`else
  localparam ser_state_t FIRST_ST = SEND_LO;
`endif

  ser_state_t              state_q, state_d;
  logic [RESULT_WIDTH-1:0] act_q, act_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    tx_valid_q, tx_valid_d;
  logic                    overrun_q, overrun_d;
  logic [RESULT_WIDTH-1:0] hold_data;
  logic                    hold_full;
  logic                    hold_wr;
  logic                    hold_pop;
  logic                    load_act;
  logic                    ovr_set;
  logic                    hs;

  assign hs = tx_valid_q & bus.TX_READY;

  alu_res_hold #(
    .WIDTH (RESULT_WIDTH)
  ) u_hold (
    .CLK    (CLK),
    .RST    (RST),
    .wr_i   (hold_wr),
    .din_i  (bus.ALU_OUT),
    .pop_i  (hold_pop),
    .dout_o (hold_data),
    .full_o (hold_full)
  );

  // Next state, active-register load, hold-buffer control and overrun detection.
  always_comb begin : fsm_next
    state_d  = state_q;
    act_d    = act_q;
    hold_pop = 1'b0;
    load_act = 1'b0;
    hold_wr  = 1'b0;
    ovr_set  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.OUT_VALID) begin
          act_d    = bus.ALU_OUT;
          load_act = 1'b1;
          state_d  = FIRST_ST;
        end
      end
`ifdef ALU_RES_HDR_EN
      SEND_HDR: begin
        if (hs) state_d = SEND_LO;
      end
`endif
      SEND_LO: begin
        if (hs) state_d = SEND_HI;
      end
      SEND_HI: begin
        if (hs) begin
          if (hold_full) begin
            act_d    = hold_data;
            hold_pop = 1'b1;
            state_d  = FIRST_ST;
          end else if (bus.OUT_VALID) begin
            act_d    = bus.ALU_OUT;
            load_act = 1'b1;
            state_d  = FIRST_ST;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A result the FSM cannot take goes to the hold entry, or is dropped if that is occupied.
    if (bus.OUT_VALID && !load_act) begin
      if (!hold_full || hold_pop) hold_wr = 1'b1;
      else                        ovr_set = 1'b1;
    end
  end

  // Byte mux evaluated on next state so TX_DATA/TX_VALID come straight from flops.
  always_comb begin : tx_next
    tx_valid_d = (state_d != IDLE);
    tx_data_d  = '0;
    case (state_d)
      SEND_LO: tx_data_d = DATA_WIDTH'(act_d[DATA_WIDTH-1:0]);
      SEND_HI: tx_data_d = DATA_WIDTH'(act_d[RESULT_WIDTH-1:DATA_WIDTH]);
`ifdef ALU_RES_HDR_EN
      SEND_HDR: tx_data_d = HDR_BYTE;
`endif
      default: tx_data_d = '0;
    endcase
  end

  // Set beats clear when both happen in one cycle.
  always_comb begin : ovr_next
    overrun_d = overrun_q;
    if (ovr_set)              overrun_d = 1'b1;
    else if (bus.CLR_OVERRUN) overrun_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST) begin : ser_reg
    if (!RST) begin
      state_q    <= IDLE;
      act_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_q      <= act_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.TX_DATA  = tx_data_q;
  assign bus.TX_VALID = tx_valid_q;
  assign bus.BUSY     = hold_full;
  assign bus.OVERRUN  = overrun_q;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Self-checking bench for alu_result_serializer: directed scenarios plus random traffic
// against a frame-queue reference model.
module tb_alu_result_serializer;

`ifdef ALU_RES_HDR_EN
  localparam int FRAME_LEN = 3;
`else
  localparam int FRAME_LEN = 2;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;

  alu_result_serializer_if #(.DATA_WIDTH(8), .RESULT_WIDTH(16)) bus();

  alu_result_serializer dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int busy_cycles = 0;

  // Reference model: results waiting to leave (head is on the wire), byte index into head.
  logic [15:0] mq[$];
  int          m_idx = 0;
  bit          m_ovr = 1'b0;

  logic [7:0] got[$];
  logic [7:0] exp_s[$];

  function automatic logic [7:0] byte_of(input logic [15:0] w, input int idx);
    logic [7:0] b;
`ifdef ALU_RES_HDR_EN
    if (idx == 0)      b = 8'hA5;
    else if (idx == 1) b = w[7:0];
    else               b = w[15:8];
`else
    if (idx == 0) b = w[7:0];
    else          b = w[15:8];
`endif
    return b;
  endfunction

  function automatic void push_frame(input logic [15:0] w);
    for (int i = 0; i < FRAME_LEN; i++) exp_s.push_back(byte_of(w, i));
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_idx = 0;
    m_ovr = 1'b0;
  endfunction

  function automatic void model_edge(input logic ov, input logic [15:0] alu,
                                     input logic rdy, input logic clr);
    bit drop;
    if (mq.size() > 0 && rdy) begin
      m_idx++;
      if (m_idx == FRAME_LEN) begin
        void'(mq.pop_front());
        m_idx = 0;
      end
    end
    drop = ov && (mq.size() >= 2);
    if (ov && !drop) mq.push_back(alu);
    if (drop)     m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("TX_VALID", 16'(bus.TX_VALID), 16'(mq.size() > 0));
    chk("BUSY",     16'(bus.BUSY),     16'(mq.size() >= 2));
    chk("OVERRUN",  16'(bus.OVERRUN),  16'(m_ovr));
    if (mq.size() > 0) chk("TX_DATA", 16'(bus.TX_DATA), 16'(byte_of(mq[0], m_idx)));
  endtask

  task automatic step(input logic ov, input logic [15:0] alu, input logic rdy, input logic clr);
    bus.OUT_VALID   = ov;
    bus.ALU_OUT     = alu;
    bus.TX_READY    = rdy;
    bus.CLR_OVERRUN = clr;
    if (bus.TX_VALID && rdy) got.push_back(bus.TX_DATA);
    @(posedge CLK);
    model_edge(ov, alu, rdy, clr);
    #1;
    chk_model();
    if (bus.BUSY) busy_cycles++;
  endtask

  task automatic chk_stream(input string tag);
    chk({tag, "_len"}, 16'(got.size()), 16'(exp_s.size()));
    for (int i = 0; i < exp_s.size() && i < got.size(); i++)
      chk(tag, 16'(got[i]), 16'(exp_s[i]));
    got.delete();
    exp_s.delete();
  endtask

  initial begin
    bus.OUT_VALID   = 1'b0;
    bus.ALU_OUT     = '0;
    bus.TX_READY    = 1'b0;
    bus.CLR_OVERRUN = 1'b0;

    // Reset values
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_TX_VALID", 16'(bus.TX_VALID), 16'h0);
    chk("rst_TX_DATA",  16'(bus.TX_DATA),  16'h0);
    chk("rst_BUSY",     16'(bus.BUSY),     16'h0);
    chk("rst_OVERRUN",  16'(bus.OVERRUN),  16'h0);
    RST = 1'b1;
    model_reset();
    step(1'b0, 16'h0, 1'b1, 1'b0);

    // Single result
    step(1'b1, 16'h1234, 1'b1, 1'b0);
    repeat (FRAME_LEN + 1) step(1'b0, 16'h0, 1'b1, 1'b0);
    push_frame(16'h1234);
    chk_stream("single");

    // Backpressure
    step(1'b1, 16'hBEEF, 1'b0, 1'b0);
    repeat (5) step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("bp_stall_len", 16'(got.size()), 16'h0);
    repeat (FRAME_LEN + 1) step(1'b0, 16'h0, 1'b1, 1'b0);
    push_frame(16'hBEEF);
    chk_stream("backpressure");

    // Hold buffer, back-to-back results
    busy_cycles = 0;
    step(1'b1, 16'h0001, 1'b1, 1'b0);
    step(1'b1, 16'h0203, 1'b1, 1'b0);
    repeat (2 * FRAME_LEN + 1) step(1'b0, 16'h0, 1'b1, 1'b0);
    push_frame(16'h0001);
    push_frame(16'h0203);
    chk_stream("hold");
    chk("hold_busy_cycles", 16'(busy_cycles), 16'(FRAME_LEN - 1));

    // Overrun: third result dropped, clear, then set-beats-clear
    step(1'b1, 16'h1111, 1'b0, 1'b0);
    step(1'b1, 16'h2222, 1'b0, 1'b0);
    step(1'b1, 16'h3333, 1'b0, 1'b0);
    chk("ovr_set", 16'(bus.OVERRUN), 16'h1);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("ovr_clr", 16'(bus.OVERRUN), 16'h0);
    step(1'b1, 16'h4444, 1'b0, 1'b1);
    chk("ovr_set_wins", 16'(bus.OVERRUN), 16'h1);
    repeat (2 * FRAME_LEN + 1) step(1'b0, 16'h0, 1'b1, 1'b0);
    push_frame(16'h1111);
    push_frame(16'h2222);
    chk_stream("overrun");
    step(1'b0, 16'h0, 1'b1, 1'b1);

    // Header framing (plain two-byte frame when the header is not configured)
    step(1'b1, 16'h00FF, 1'b1, 1'b0);
    repeat (FRAME_LEN + 1) step(1'b0, 16'h0, 1'b1, 1'b0);
    push_frame(16'h00FF);
    chk_stream("hdr_frame");

    // Reset mid-frame with a result also in the hold entry
    step(1'b1, 16'h5678, 1'b1, 1'b0);
    step(1'b1, 16'h9ABC, 1'b1, 1'b0);
    RST = 1'b0;
    #1;
    chk("midrst_TX_VALID", 16'(bus.TX_VALID), 16'h0);
    chk("midrst_TX_DATA",  16'(bus.TX_DATA),  16'h0);
    chk("midrst_BUSY",     16'(bus.BUSY),     16'h0);
    chk("midrst_OVERRUN",  16'(bus.OVERRUN),  16'h0);
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b1;
    repeat (4) step(1'b0, 16'h0, 1'b1, 1'b0);
    exp_s.push_back(byte_of(16'h5678, 0));
    chk_stream("midrst");

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 2) == 0), 16'($urandom),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0));
    end
    repeat (3 * FRAME_LEN) step(1'b0, 16'h0, 1'b1, 1'b1);
    chk("drain_idle", 16'(bus.TX_VALID), 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
